// File: rtl/pe_sched_pkg.sv
// Shared types and defaults for the PE phase scheduler: state encoding,
// registered-output bundle and the output decode for a given state.
package pe_sched_pkg;

    localparam int PASS_W_DEF  = 8;
    localparam int DEPTH_W_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_WR = 3'd2,
        ST_LOAD    = 3'd3,
        ST_CALC    = 3'd4,
        ST_ACC     = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } sched_state_e;

    typedef struct packed {
        logic do_load;
        logic psum_enq;
        logic iact_clr;
        logic wgt_clr;
        logic spad_clr;
        logic done;
        logic busy;
    } sched_out_t;

    // Outputs to present while in state nxt; abort_i marks the cycle entered via abort.
    function automatic sched_out_t decode_outputs(input sched_state_e nxt,
                                                  input logic         abort_i,
                                                  input logic         last_i);
        sched_out_t o;
        o          = '0;
        o.busy     = (nxt != ST_IDLE);
        o.spad_clr = (nxt == ST_CLEAR);
        o.do_load  = (nxt == ST_LOAD);
        o.psum_enq = (nxt == ST_ACC);
        o.done     = (nxt == ST_DONE);
        o.wgt_clr  = abort_i | (nxt == ST_CLEAR) | (nxt == ST_DONE);
        o.iact_clr = o.wgt_clr | ((nxt == ST_NEXT) & ~last_i);
        return o;
    endfunction

endpackage

// File: rtl/pe_sched_pass_counter.sv
// Pass counter for the PE phase scheduler: latched pass total N (0 taken
// as 1), current pass index and the terminal (index == N-1) flag.
module pe_sched_pass_counter
    import pe_sched_pkg::*;
#(
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [PASS_W-1:0] num_passes_i,
    input  logic              inc_i,
    output logic [PASS_W-1:0] count_o,
    output logic              last_o
);

    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    logic [PASS_W-1:0] n_q;
    logic [PASS_W-1:0] n_d;
    logic [PASS_W-1:0] count_q;
    logic [PASS_W-1:0] count_d;

    // Next pass total and index; abort clears win over a new tile load.
    always_comb begin
        n_d     = n_q;
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            n_d     = (num_passes_i == '0) ? PASS_ONE : num_passes_i;
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + PASS_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Pass registers; N resets to 1 so N-1 never underflows.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_q     <= PASS_ONE;
            count_q <= '0;
        end else begin
            n_q     <= n_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == (n_q - PASS_ONE));

endmodule

// File: rtl/pe_phase_scheduler.sv
// Tile sequencer for one Processing_Element: clear, wait write, load, compute,
// optional psum accumulate, with iact passes reusing one weight load.
// Build option: PE_SCHED_PSUM_ACC_EN enables the ACC (psum accumulate) state.
module pe_phase_scheduler
    import pe_sched_pkg::*;
#(
    parameter int PASS_W  = PASS_W_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PASS_W-1:0]  num_passes,
    input  logic [DEPTH_W-1:0] psum_depth_cfg,
    input  logic               all_write_fin,
    input  logic               cal_fin,
    input  logic               psum_add_fin,
    output logic               do_load_en,
    output logic               psum_enq_en,
    output logic               iact_write_fin_clear,
    output logic               weight_write_fin_clear,
    output logic               psum_spad_clear,
    output logic [DEPTH_W-1:0] PSUM_DEPTH,
    output logic [PASS_W-1:0]  pass_count,
    output logic               busy,
    output logic               done
);

    sched_state_e       state_q;
    sched_state_e       state_d;
    sched_out_t         out_q;
    sched_out_t         out_d;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               start_ok_s;
    logic               inc_s;
    logic               last_s;

    pe_sched_pass_counter #(
        .PASS_W(PASS_W)
    ) u_pass_counter (
        .clock        (clock),
        .reset        (reset),
        .clr_i        (abort),
        .load_i       (start_ok_s),
        .num_passes_i (num_passes),
        .inc_i        (inc_s),
        .count_o      (pass_count),
        .last_o       (last_s)
    );

    // Next-state logic; status inputs only matter in their own waiting state.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        start_ok_s = 1'b0;
        inc_s      = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        start_ok_s = 1'b1;
                        depth_d    = psum_depth_cfg;
                        state_d    = ST_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLEAR:   state_d = ST_WAIT_WR;
                ST_WAIT_WR: begin
                    if (all_write_fin) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_WAIT_WR;
                    end
                end
                ST_LOAD:    state_d = ST_CALC;
                ST_CALC: begin
                    if (cal_fin) begin
`ifdef PE_SCHED_PSUM_ACC_EN
                        state_d = ST_ACC;
`else
                        state_d = ST_NEXT;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_ACC: begin
`ifdef PE_SCHED_PSUM_ACC_EN
                    if (psum_add_fin) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_ACC;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_NEXT: begin
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        inc_s   = 1'b1;
                        state_d = ST_WAIT_WR;
                    end
                end
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
        // pass_count only moves when leaving NEXT, so last_s is valid for the state being entered.
        out_d = decode_outputs(state_d, abort, last_s);
    end

    // State, latched depth and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            out_q   <= out_d;
        end
    end

    assign do_load_en             = out_q.do_load;
    assign iact_write_fin_clear   = out_q.iact_clr;
    assign weight_write_fin_clear = out_q.wgt_clr;
    assign psum_spad_clear        = out_q.spad_clr;
    assign busy                   = out_q.busy;
    assign done                   = out_q.done;
    assign PSUM_DEPTH             = depth_q;

`ifdef PE_SCHED_PSUM_ACC_EN
    assign psum_enq_en = out_q.psum_enq;
`else
    logic unused_acc_s;
    assign unused_acc_s = psum_add_fin ^ out_q.psum_enq;
    assign psum_enq_en  = 1'b0;
`endif

endmodule

// File: tb/tb_pe_phase_scheduler.sv
// Self-checking bench for pe_phase_scheduler: table of tiles run against a
// PE response model with a pass_count scoreboard, plus abort/reset/ignore cases.
module tb_pe_phase_scheduler;

`ifdef PE_SCHED_PSUM_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] num_passes;
    logic [4:0] psum_depth_cfg;
    logic       all_write_fin;
    logic       cal_fin;
    logic       psum_add_fin;
    logic       do_load_en;
    logic       psum_enq_en;
    logic       iact_write_fin_clear;
    logic       weight_write_fin_clear;
    logic       psum_spad_clear;
    logic [4:0] PSUM_DEPTH;
    logic [7:0] pass_count;
    logic       busy;
    logic       done;

    pe_phase_scheduler #(
        .PASS_W  (8),
        .DEPTH_W (5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .abort                  (abort),
        .num_passes             (num_passes),
        .psum_depth_cfg         (psum_depth_cfg),
        .all_write_fin          (all_write_fin),
        .cal_fin                (cal_fin),
        .psum_add_fin           (psum_add_fin),
        .do_load_en             (do_load_en),
        .psum_enq_en            (psum_enq_en),
        .iact_write_fin_clear   (iact_write_fin_clear),
        .weight_write_fin_clear (weight_write_fin_clear),
        .psum_spad_clear        (psum_spad_clear),
        .PSUM_DEPTH             (PSUM_DEPTH),
        .pass_count             (pass_count),
        .busy                   (busy),
        .done                   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int np;
        int dep;
        int dly;
        int exp_loads;
        int exp_busy_acc;
        int exp_busy_noacc;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int dly;
    int wr_cnt;
    int cal_cnt;
    int add_cnt;
    bit prev_enq;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({do_load_en, psum_enq_en, iact_write_fin_clear, weight_write_fin_clear,
                     psum_spad_clear, PSUM_DEPTH, pass_count, busy, done});
    endfunction

    task automatic model_reset();
        all_write_fin = 1'b0;
        cal_fin       = 1'b0;
        psum_add_fin  = 1'b0;
        wr_cnt        = 0;
        cal_cnt       = 0;
        add_cnt       = 0;
        prev_enq      = 1'b0;
    endtask

    // PE model: each status rises dly+1 cycles into its waiting phase.
    task automatic pe_step();
        if (iact_write_fin_clear) begin
            wr_cnt        = dly;
            all_write_fin = 1'b0;
        end else if (!all_write_fin) begin
            if (wr_cnt == 0) all_write_fin = 1'b1;
            else wr_cnt--;
        end
        if (do_load_en) begin
            cal_cnt = dly;
            cal_fin = 1'b0;
        end else if (!cal_fin) begin
            if (cal_cnt == 0) cal_fin = 1'b1;
            else cal_cnt--;
        end
        if (psum_enq_en && !prev_enq) begin
            add_cnt      = dly;
            psum_add_fin = (dly == 0);
        end else if (psum_enq_en && !psum_add_fin) begin
            add_cnt--;
            if (add_cnt == 0) psum_add_fin = 1'b1;
        end
        prev_enq = psum_enq_en;
    endtask

    task automatic run_tile(input vec_t v);
        int  n_eff;
        int  cyc;
        int  loads;
        int  clears;
        int  dones;
        int  enqs;
        int  busy_cyc;
        int  depth_bad;
        int  exp_pc;
        bit  fin;
        bit  enq_prev;
        n_eff = (v.np == 0) ? 1 : v.np;
        dly   = v.dly;
        model_reset();
        loads = 0; clears = 0; dones = 0; enqs = 0; busy_cyc = 0; depth_bad = 0;
        for (int p = 0; p < n_eff; p++) exp_q.push_back(p);
        start          = 1'b1;
        num_passes     = 8'(v.np);
        psum_depth_cfg = 5'(v.dep);
        @(negedge clock);
        start = 1'b0;
        check("spad_clear_latency", int'(psum_spad_clear), 1);
        cyc = 0; fin = 1'b0; enq_prev = 1'b0;
        while (!fin && cyc < 2000) begin
            if (busy) busy_cyc++;
            if (busy && (int'(PSUM_DEPTH) != v.dep)) depth_bad++;
            if (psum_spad_clear) clears++;
            if (psum_enq_en && !enq_prev) enqs++;
            enq_prev = psum_enq_en;
            if (do_load_en) begin
                loads++;
                if (exp_q.size() == 0) begin
                    check("load_overrun", loads, n_eff);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("pass_count_at_load", int'(pass_count), exp_pc);
                end
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            pe_step();
            @(negedge clock);
            cyc++;
        end
        check("tile_finished", int'(fin), 1);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("load_count", loads, v.exp_loads);
        check("spad_clear_count", clears, 1);
        check("done_count", dones, 1);
        check("psum_enq_count", enqs, ACC_EN ? n_eff : 0);
        check("busy_cycles", busy_cyc, ACC_EN ? v.exp_busy_acc : v.exp_busy_noacc);
        check("psum_depth_held", depth_bad, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
        model_reset();
    endtask

    vec_t vecs[5];
    int   found;
    int   seen_done;

    initial begin
        // busy cycles = CLEAR + DONE + N * pass length; pass = 5+3*dly with ACC, 4+2*dly without
        vecs[0] = '{3, 16, 2, 3, 35, 26};
        vecs[1] = '{0,  7, 0, 1,  7,  6};
        vecs[2] = '{1, 31, 1, 1, 10,  8};
        vecs[3] = '{2,  0, 0, 2, 12, 10};
        vecs[4] = '{4,  5, 1, 4, 34, 26};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        num_passes = 8'd0; psum_depth_cfg = 5'd0;
        dly = 0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_outputs", out_vec(), 0);
        end

        for (int i = 0; i < 5; i++) run_tile(vecs[i]);

        // abort together with start while in CALC of pass 1
        dly = 3;
        model_reset();
        start = 1'b1; num_passes = 8'd3; psum_depth_cfg = 5'd12;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (do_load_en && pass_count == 8'd1) found = 1;
            pe_step();
            @(negedge clock);
        end
        check("abort_reached_pass1", found, 1);
        check("abort_in_calc", int'({busy, do_load_en}), 2);
        abort = 1'b1; start = 1'b1;
        @(negedge clock);
        abort = 1'b0; start = 1'b0;
        model_reset();
        check("abort_busy", int'(busy), 0);
        check("abort_pass_count", int'(pass_count), 0);
        check("abort_iact_clear", int'(iact_write_fin_clear), 1);
        check("abort_weight_clear", int'(weight_write_fin_clear), 1);
        check("abort_no_done", int'(done), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("abort_start_ignored", int'({busy, done, iact_write_fin_clear}), 0);
        end

        // cal_fin pulse in WAIT_WR must not advance the FSM
        start = 1'b1; num_passes = 8'd1; psum_depth_cfg = 5'd9;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        cal_fin = 1'b1;
        @(negedge clock);
        cal_fin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("wait_wr_holds", int'({busy, do_load_en, psum_enq_en}), 4);
            @(negedge clock);
        end
        all_write_fin = 1'b1;
        @(negedge clock);
        check("load_after_write_fin", int'(do_load_en), 1);
        @(negedge clock);
        check("calc_no_load", int'({busy, do_load_en}), 2);
        cal_fin = 1'b1; psum_add_fin = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 20 && seen_done == 0; c++) begin
            @(negedge clock);
            if (done) seen_done = 1;
        end
        check("wait_case_done", seen_done, 1);
        model_reset();
        @(negedge clock);

        // reset mid-tile
        dly = 1;
        start = 1'b1; num_passes = 8'd2; psum_depth_cfg = 5'd21;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            pe_step();
            @(negedge clock);
        end
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("mid_tile_reset", out_vec(), 0);
        @(negedge clock);
        check("post_reset_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
